// File: rtl/alu_op_sequencer.sv
// Command-frame sequencer for the system ALU: collects func/A/B bytes, runs one ALU op, streams the result back low byte first.
// Optional EXEC watchdog is compiled in when ALU_TIMEOUT_EN is defined.
module alu_op_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int FUNC_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     A,
    output logic [DATA_WIDTH-1:0]     B,
    output logic [FUNC_WIDTH-1:0]     ALU_FUN,
    output logic                      ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_VALID,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_SEND_LO,
        S_SEND_HI
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     a_q, a_d;
    logic [DATA_WIDTH-1:0]     b_q, b_d;
    logic [FUNC_WIDTH-1:0]     fun_q, fun_d;
    logic [2*DATA_WIDTH-1:0]   result_q, result_d;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            result_q <= '0;
`ifdef ALU_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fun_q    <= fun_d;
            result_q <= result_d;
`ifdef ALU_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        fun_d    = fun_q;
        result_d = result_q;
`ifdef ALU_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    fun_d   = in_data[FUNC_WIDTH-1:0];
                    state_d = S_GET_A;
                end
            end
            S_GET_A: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (in_valid) begin
                    b_d     = in_data;
                    state_d = S_EXEC;
`ifdef ALU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_EXEC: begin
                if (ALU_VALID) begin
                    result_d = ALU_OUT;
                    state_d  = S_SEND_LO;
`ifdef ALU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Last permitted enable cycle elapsed without a result: abandon the command.
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
`endif
                end
            end
            S_SEND_LO: begin
                if (out_ready) begin
                    state_d = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All handshake outputs decode straight from state so they hold steady under backpressure.
    assign in_ready  = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
    assign ALU_EN    = (state_q == S_EXEC);
    assign out_valid = (state_q == S_SEND_LO) || (state_q == S_SEND_HI);
    assign out_data  = (state_q == S_SEND_LO) ? result_q[DATA_WIDTH-1:0] :
                       (state_q == S_SEND_HI) ? result_q[2*DATA_WIDTH-1:DATA_WIDTH] :
                                                '0;
    assign busy      = (state_q != S_IDLE);
    assign A         = a_q;
    assign B         = b_q;
    assign ALU_FUN   = fun_q;

`ifdef ALU_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a one-cycle ALU model feeds results, a byte-queue reference predicts the output stream.
module tb_alu_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A, B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_VALID;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] exp_a, exp_b;
    logic [3:0] exp_f;
    int         ready_mode = 0;   // 0: ready high, 1: random, 2: ready low
    logic       alu_stuck = 1'b0;
    int         err_cnt = 0;
    int         en_cnt = 0;

    alu_op_sequencer dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] t;
        case (f)
            4'h0: return 16'(a) + 16'(b);
            4'h1: return 16'(a) - 16'(b);
            4'h2: return 16'(a) * 16'(b);
            4'h3: return (b != 0) ? 16'(a / b) : 16'h0;
            4'h4: return {8'h00, a & b};
            4'h5: return {8'h00, a | b};
            4'h6: begin t = ~(a & b); return {8'h00, t}; end
            4'h7: begin t = ~(a | b); return {8'h00, t}; end
            4'h8: return {8'h00, a ^ b};
            4'h9: begin t = ~(a ^ b); return {8'h00, t}; end
            4'hA: return (a == b) ? 16'd1 : 16'd0;
            4'hB: return (a > b) ? 16'd2 : 16'd0;
            4'hC: return (a < b) ? 16'd3 : 16'd0;
            4'hD: return {8'h00, a >> 1};
            4'hE: return 16'(a) << 1;
            default: return 16'h0;
        endcase
    endfunction

    // One-cycle registered ALU; drops its outputs as soon as enable goes low.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_VALID <= 1'b0;
            ALU_OUT   <= 16'h0;
        end else begin
            ALU_VALID <= ALU_EN && !alu_stuck;
            ALU_OUT   <= ALU_EN ? alu_fn(ALU_FUN, A, B) : 16'h0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom % 2);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       hi_next = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_q.delete();
                prev_stall = 1'b0;
                hi_next = 1'b0;
                en_cnt = 0;
            end else begin
                check_eq("in_ready_rule", 32'(in_ready), 32'(!(ALU_EN || out_valid)));
`ifdef ALU_TIMEOUT_EN
                if (err_timeout) begin
                    err_cnt++;
                    check_eq("timeout_en_cycles", en_cnt, 15);
                    en_cnt = 0;
                end
`else
                check_eq("err_timeout_zero", 32'(err_timeout), 32'd0);
`endif
                if (prev_stall) begin
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_data", 32'(out_data), 32'(prev_data));
                end
                if (ALU_EN) begin
                    en_cnt++;
                    check_eq("exec_operands", {12'h0, ALU_FUN, A, B}, {12'h0, exp_f, exp_a, exp_b});
                end
                if (out_valid && out_ready) begin
                    check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq(hi_next ? "out_hi" : "out_lo", 32'(out_data), 32'(e));
                    end
                    if (!hi_next) begin
                        check_eq("alu_en_cycles", en_cnt, 2);
                        en_cnt = 0;
                    end
                    sent_q.push_back(out_data);
                    hi_next = !hi_next;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        forever begin
            @(negedge CLK);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_frame(input logic [7:0] f, input logic [7:0] a, input logic [7:0] b, input bit push);
        logic [15:0] r;
        exp_f = f[3:0];
        exp_a = a;
        exp_b = b;
        if (push) begin
            r = alu_fn(f[3:0], a, b);
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
        end
        send_byte(f);
        send_byte(a);
        send_byte(b);
    endtask

    // Waits for IDLE while waving junk at the (closed) input port.
    task automatic finish_frame();
        int n = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!busy) begin
                in_valid = 1'b0;
                break;
            end
            in_valid = 1'($urandom % 2);
            in_data  = 8'($urandom);
            n++;
            if (n > 300) begin
                in_valid = 1'b0;
                check_eq("frame_timeout", 32'(busy), 32'd0);
                break;
            end
        end
        @(negedge CLK);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_eq("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic pulse_reset();
        #1;
        RST = 1'b1;
        #1;
        check_eq("async_rst_outputs", {A, B, ALU_FUN, ALU_EN, out_valid, out_data, busy, err_timeout}, 32'h0);
        check_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    initial begin
        int base;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        RST = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("reset_outputs", {A, B, ALU_FUN, ALU_EN, out_valid, out_data, busy, err_timeout}, 32'h0);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // add: 5 + 3
        start_frame(8'h00, 8'h05, 8'h03, 1'b1);
        finish_frame();
        check_eq("add_lo", 32'(sent_q[sent_q.size()-2]), 32'h08);
        check_eq("add_hi", 32'(sent_q[sent_q.size()-1]), 32'h00);

        // mul: 0xFF * 0xFF
        start_frame(8'h02, 8'hFF, 8'hFF, 1'b1);
        finish_frame();
        check_eq("mul_lo", 32'(sent_q[sent_q.size()-2]), 32'h01);
        check_eq("mul_hi", 32'(sent_q[sent_q.size()-1]), 32'hFE);

        // compare-greater with junk in the upper nibble
        start_frame(8'hFB, 8'h09, 8'h03, 1'b1);
        finish_frame();
        check_eq("cmp_fun", 32'(ALU_FUN), 32'hB);
        check_eq("cmp_lo", 32'(sent_q[sent_q.size()-2]), 32'h02);
        check_eq("cmp_hi", 32'(sent_q[sent_q.size()-1]), 32'h00);

        // backpressure on the low byte
        ready_mode = 2;
        base = sent_q.size();
        start_frame(8'h00, 8'h10, 8'h20, 1'b1);
        wait_out_valid();
        repeat (5) begin
            @(negedge CLK);
            check_eq("bp_data", 32'(out_data), 32'h30);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge CLK);
        #1;
        ready_mode = 0;
        finish_frame();
        check_eq("bp_byte_count", sent_q.size() - base, 2);
        check_eq("bp_lo", 32'(sent_q[sent_q.size()-2]), 32'h30);

        // reset in GET_B
        send_byte(8'h01);
        send_byte(8'h44);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        pulse_reset();
        start_frame(8'h01, 8'h44, 8'h11, 1'b1);
        finish_frame();
        check_eq("post_rst1_lo", 32'(sent_q[sent_q.size()-2]), 32'h33);

        // reset in SEND_HI
        ready_mode = 2;
        start_frame(8'h00, 8'h80, 8'h90, 1'b1);
        wait_out_valid();
        ready_mode = 0;
        @(posedge CLK);
        #1;
        ready_mode = 2;
        check_eq("in_send_hi", 32'(out_valid), 32'd1);
        pulse_reset();
        ready_mode = 0;
        start_frame(8'h00, 8'h80, 8'h90, 1'b1);
        finish_frame();
        check_eq("post_rst2_lo", 32'(sent_q[sent_q.size()-2]), 32'h10);
        check_eq("post_rst2_hi", 32'(sent_q[sent_q.size()-1]), 32'h01);

`ifdef ALU_TIMEOUT_EN
        alu_stuck = 1'b1;
        base = sent_q.size();
        start_frame(8'h00, 8'h01, 8'h02, 1'b0);
        finish_frame();
        alu_stuck = 1'b0;
        check_eq("timeout_pulses", err_cnt, 1);
        check_eq("timeout_no_bytes", sent_q.size() - base, 0);
        start_frame(8'h00, 8'h01, 8'h02, 1'b1);
        finish_frame();
        check_eq("after_timeout_lo", 32'(sent_q[sent_q.size()-2]), 32'h03);
`endif

        // randomized frames with random downstream backpressure
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            start_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            finish_frame();
        end
        ready_mode = 0;
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
